// File: rtl/ow_byte_assembler.sv
// 1-Wire receive byte assembler: shifts slot bits LSB-first into words and
// queues completed words in a first-word-fall-through FIFO for the command decoder.
module ow_byte_assembler #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_reset_det,
  input  logic              i_bit_val,
  input  logic              i_bit_ready,
  output logic [DATA_W-1:0] o_byte,
  output logic              o_byte_valid,
  input  logic              i_byte_ready,
  output logic              o_frame_start,
  output logic [CNT_W-1:0]  o_byte_cnt,
  output logic              o_overrun,
  output logic              o_frame_err
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  state_t            r_state;
  logic [DATA_W-1:0] r_shreg;
  logic [BCW-1:0]    r_bitcnt;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic              r_frame_start;
  logic              r_frame_err;
  logic [CNT_W-1:0]  r_byte_cnt;
  logic              r_overrun;

  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_bit_acc;
  logic              w_byte_done;
  logic              w_push;
  logic              w_drop;
  logic [DATA_W-1:0] w_next_shreg;

  assign w_empty      = (r_wptr == r_rptr);
  assign w_full       = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop        = !w_empty && i_byte_ready;
  // A coincident bus reset always beats the slot bit.
  assign w_bit_acc    = (r_state == S_ACTIVE) && i_bit_ready && !i_reset_det;
  assign w_byte_done  = w_bit_acc && (r_bitcnt == BCW'(DATA_W - 1));
  assign w_push       = w_byte_done && (!w_full || w_pop);
  assign w_drop       = w_byte_done && w_full && !w_pop;
  assign w_next_shreg = {i_bit_val, r_shreg[DATA_W-1:1]};

  assign o_byte        = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign o_byte_valid  = !w_empty;
  assign o_frame_start = r_frame_start;
  assign o_frame_err   = r_frame_err;
  assign o_byte_cnt    = r_byte_cnt;
  assign o_overrun     = r_overrun;

  // Storage carries data only; emptiness is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= w_next_shreg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_shreg       <= '0;
      r_bitcnt      <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_frame_start <= 1'b0;
      r_frame_err   <= 1'b0;
      r_byte_cnt    <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_frame_err   <= 1'b0;
      if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
      if (i_reset_det) begin
        // Re-arm for a new frame; queued bytes keep draining.
        r_state       <= S_ACTIVE;
        r_frame_start <= 1'b1;
        r_frame_err   <= (r_state == S_ACTIVE) && (r_bitcnt != '0);
        r_bitcnt      <= '0;
        r_shreg       <= '0;
        r_byte_cnt    <= '0;
        r_overrun     <= 1'b0;
      end else if (w_bit_acc) begin
        r_shreg  <= w_next_shreg;
        r_bitcnt <= w_byte_done ? '0 : r_bitcnt + BCW'(1);
        if (w_push) begin
          r_wptr     <= r_wptr + (AW+1)'(1);
          r_byte_cnt <= sat_inc(r_byte_cnt);
        end
        if (w_drop) r_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ow_byte_assembler.sv
// Bench for ow_byte_assembler: directed scenarios plus random traffic, all
// compared cycle by cycle against a queue-based frame/FIFO reference model.
module tb_ow_byte_assembler;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              i_reset_det = 1'b0;
  logic              i_bit_val = 1'b0;
  logic              i_bit_ready = 1'b0;
  logic              i_byte_ready = 1'b0;
  logic [DATA_W-1:0] o_byte;
  logic              o_byte_valid;
  logic              o_frame_start;
  logic [CNT_W-1:0]  o_byte_cnt;
  logic              o_overrun;
  logic              o_frame_err;

  ow_byte_assembler #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .i_reset_det(i_reset_det), .i_bit_val(i_bit_val),
    .i_bit_ready(i_bit_ready), .o_byte(o_byte), .o_byte_valid(o_byte_valid),
    .i_byte_ready(i_byte_ready), .o_frame_start(o_frame_start), .o_byte_cnt(o_byte_cnt),
    .o_overrun(o_overrun), .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // Reference model: frame in progress as a bit count plus accumulated value.
  bit          m_active;
  int          m_n;
  int unsigned m_acc;
  int unsigned m_q[$];
  int          m_cnt;
  bit          m_ovr, m_fs, m_fe;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_n = 0; m_acc = 0; m_q.delete();
    m_cnt = 0; m_ovr = 0; m_fs = 0; m_fe = 0;
  endtask

  task automatic model_step(input bit rd, input bit bv, input bit br, input bit rdy);
    bit pop;
    if (!reset) begin
      model_reset();
      return;
    end
    pop = (m_q.size() != 0) && rdy;
    m_fs = 0;
    m_fe = 0;
    if (pop) void'(m_q.pop_front());
    if (rd) begin
      m_fe = m_active && (m_n != 0);
      m_fs = 1; m_n = 0; m_acc = 0; m_cnt = 0; m_ovr = 0; m_active = 1;
    end else if (m_active && br) begin
      m_acc = m_acc | (int'(bv) << m_n);
      m_n++;
      if (m_n == DATA_W) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back(m_acc);
          if (m_cnt < CMAX) m_cnt++;
        end else begin
          m_ovr = 1;
        end
        m_n = 0;
        m_acc = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("byte", 32'(o_byte), (m_q.size() != 0) ? m_q[0] : 0);
    chk("valid", 32'(o_byte_valid), 32'(m_q.size() != 0));
    chk("frame_start", 32'(o_frame_start), 32'(m_fs));
    chk("frame_err", 32'(o_frame_err), 32'(m_fe));
    chk("byte_cnt", 32'(o_byte_cnt), 32'(m_cnt));
    chk("overrun", 32'(o_overrun), 32'(m_ovr));
  endtask

  task automatic step(input bit rd, input bit bv, input bit br, input bit rdy);
    i_reset_det = rd; i_bit_val = bv; i_bit_ready = br; i_byte_ready = rdy;
    @(posedge clk);
    model_step(rd, bv, br, rdy);
    #1;
    compare_all();
  endtask

  task automatic send_byte(input logic [7:0] v, input bit rdy, input bit rdy_last);
    for (int i = 0; i < DATA_W; i++) step(0, v[i], 1, (i == DATA_W-1) ? rdy_last : rdy);
  endtask

  logic [7:0] t3 [5];

  initial begin
    t3[0] = 8'h33; t3[1] = 8'hCC; t3[2] = 8'h55; t3[3] = 8'hF0; t3[4] = 8'h0F;
    model_reset();
    #2;
    compare_all();
    step(0, 0, 0, 0);
    #2 reset = 1'b1;

    // Reset mid-byte, then bits before a bus reset must be ignored.
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
    #3 reset = 1'b0;
    model_reset();
    #1;
    compare_all();
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    reset = 1'b1;
    send_byte(8'hFF, 1'b0, 1'b0);
    chk("t1_idle_valid", 32'(o_byte_valid), 0);

    // Single byte A5 with consumer ready.
    step(1, 0, 0, 1);
    chk("t2_frame_start", 32'(o_frame_start), 1);
    send_byte(8'hA5, 1'b1, 1'b1);
    chk("t2_byte", 32'(o_byte), 32'h A5);
    chk("t2_cnt", 32'(o_byte_cnt), 1);
    step(0, 0, 0, 1);
    chk("t2_drained", 32'(o_byte_valid), 0);

    // Overrun: five bytes into a four-deep FIFO, then drain.
    step(1, 0, 0, 0);
    for (int b = 0; b < 5; b++) send_byte(t3[b], 1'b0, 1'b0);
    chk("t3_overrun", 32'(o_overrun), 1);
    chk("t3_cnt", 32'(o_byte_cnt), 4);
    for (int b = 0; b < 4; b++) begin
      chk("t3_order", 32'(o_byte), 32'(t3[b]));
      step(0, 0, 0, 1);
    end
    chk("t3_empty", 32'(o_byte_valid), 0);

    // Partial byte at bus reset, then a clean 0xFF.
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0);
    step(1, 0, 0, 0);
    chk("t4_frame_err", 32'(o_frame_err), 1);
    send_byte(8'hFF, 1'b0, 1'b0);
    chk("t4_byte", 32'(o_byte), 32'h FF);
    chk("t4_cnt", 32'(o_byte_cnt), 1);
    chk("t4_ovr_clear", 32'(o_overrun), 0);
    step(0, 0, 0, 1);

    // Bus reset coincident with the eighth bit.
    step(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    chk("t5_frame_err", 32'(o_frame_err), 1);
    chk("t5_cnt", 32'(o_byte_cnt), 0);
    chk("t5_valid", 32'(o_byte_valid), 0);

    // Full FIFO with simultaneous push and pop.
    step(1, 0, 0, 0);
    for (int b = 0; b < 4; b++) send_byte(8'(8'h10 + b), 1'b0, 1'b0);
    send_byte(8'h99, 1'b0, 1'b1);
    chk("t6_overrun", 32'(o_overrun), 0);
    chk("t6_head", 32'(o_byte), 32'h 11);
    for (int b = 0; b < 5; b++) step(0, 0, 0, 1);
    chk("t6_empty", 32'(o_byte_valid), 0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
